// File: rtl/count_window_scheduler_pkg.sv
// Shared definitions for the count-window scheduler: FSM state encoding and the
// default width of the shared roll-over counter.
package count_sched_pkg;

  localparam int CNT_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } sched_state_e;

endpackage

// File: rtl/count_window_scheduler_if.sv
// Requester and shared-counter signals of the count-window scheduler.
// slave is the scheduler's view; master is the agents/counter side.
interface count_window_scheduler_if
  import count_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = CNT_W_DEFAULT
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_start;
  logic [N_REQ*WIDTH-1:0] req_len;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic                   done;
  logic [IDX_W-1:0]       done_id;
  logic                   ctr_load;
  logic                   ctr_enable;
  logic [WIDTH-1:0]       ctr_start_val;
  logic [WIDTH-1:0]       ctr_count;
  logic                   err;

  modport slave (
    input  req, req_start, req_len, ctr_count,
    output grant, busy, done, done_id, ctr_load, ctr_enable, ctr_start_val, err
  );

  modport master (
    output req, req_start, req_len, ctr_count,
    input  grant, busy, done, done_id, ctr_load, ctr_enable, ctr_start_val, err
  );

endinterface

// File: rtl/count_window_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or above rr_ptr,
// wrapping around; gnt is one-hot, gnt_idx its index (both 0 when req==0).
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N_REQ);

  // NOTE: every output and temporary gets a value before any branch, so no
  // path through this block can leave one unassigned and infer a latch.
  always_comb begin
    logic             found;
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/count_window_scheduler.sv
// Shares one WIDTH-bit roll-over counter among N_REQ requesters, one count window
// at a time. Define COUNT_CHECK_EN to build the end-of-window count check (err).
module count_window_scheduler
  import count_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = CNT_W_DEFAULT
) (
  input logic                     clk,
  input logic                     rst,
  count_window_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;

  logic [N_REQ-1:0] grant;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] done_id;
  logic             ctr_load;
  logic             ctr_enable;
  logic [WIDTH-1:0] ctr_start_val;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    start_d       = start_q;
    len_d         = len_q;
    remaining_d   = remaining_q;
    grant         = '0;
    busy          = 1'b0;
    done          = 1'b0;
    done_id       = '0;
    ctr_load      = 1'b0;
    ctr_enable    = 1'b0;
    ctr_start_val = '0;

    unique case (state_q)
      IDLE: begin
        // Start and length are captured here so later edits by the requester
        // cannot disturb a window already in flight.
        if (|bus.req) begin
          owner_d = arb_idx;
          grant_d = arb_gnt;
          start_d = bus.req_start[arb_idx*WIDTH +: WIDTH];
          len_d   = bus.req_len[arb_idx*WIDTH +: WIDTH];
          state_d = LOAD;
        end
      end

      LOAD: begin
        grant         = grant_q;
        busy          = 1'b1;
        ctr_load      = 1'b1;
        ctr_start_val = start_q;
        remaining_d   = len_q;
        state_d       = (len_q != '0) ? RUN : DONE;
      end

      RUN: begin
        grant         = grant_q;
        busy          = 1'b1;
        ctr_enable    = 1'b1;
        ctr_start_val = start_q;
        remaining_d   = remaining_q - WIDTH'(1);
        if (remaining_q == WIDTH'(1)) state_d = DONE;
      end

      DONE: begin
        busy          = 1'b1;
        done          = 1'b1;
        done_id       = owner_q;
        ctr_start_val = start_q;
        rr_ptr_d      = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      start_q     <= '0;
      len_q       <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      start_q     <= start_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
    end
  end

  assign bus.grant         = grant;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.done_id       = done_id;
  assign bus.ctr_load      = ctr_load;
  assign bus.ctr_enable    = ctr_enable;
  assign bus.ctr_start_val = ctr_start_val;

`ifdef COUNT_CHECK_EN
  logic             err_q, err_d;
  logic [WIDTH-1:0] end_val;

  // The counter wraps modulo 2^WIDTH, which the truncating add reproduces.
  always_comb begin
    end_val = start_q + len_q;
    err_d   = err_q;
    if (state_q == DONE && bus.ctr_count != end_val) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  logic unused_ctr_count;
  assign unused_ctr_count = ^bus.ctr_count;
  assign bus.err          = 1'b0;
`endif

endmodule
